// File: rtl/uart_pkg.sv
// Shared UART debug-path constants and the printf loader state encoding.
package uart_pkg;

  localparam int CLK_FRE  = 27;
  localparam int UART_FRE = 115200;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 circular byte FIFO with an explicit occupancy counter.
// The caller guarantees no write when full and no pop when empty.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  input  logic             pop_i,
  output logic [7:0]       rd_data_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    level_d = level_q;
    case ({wr_en_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/uart_printf_queue.sv
// Captures whole printf messages into a byte FIFO (MSB first) and feeds
// uart_tx one byte at a time through a single valid/ready output register.
module uart_printf_queue
  import uart_pkg::*;
#(
  parameter int DATA_NUM = 1,
  parameter int DEPTH    = 16,
  parameter int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_NUM*8-1:0] send_data,
  input  logic                  printf,
  input  logic                  tx_data_ready,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  output logic [LVL_W-1:0]      level,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CNT_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

  ld_state_e             state_q, state_d;
  logic                  printf_q;
  logic [DATA_NUM*8-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            txd_q, txd_d;
  logic                  txv_q, txv_d;

  logic                  printf_rise, room, drop, wr_en, pop, xfer;
  logic [7:0]            fifo_rd_data;
  logic [LVL_W-1:0]      fifo_level;

  assign printf_rise = printf & ~printf_q;
  // Room is reserved at capture; the loader is the only writer afterwards.
  assign room  = (int'(fifo_level) + DATA_NUM) <= DEPTH;
  assign wr_en = (state_q == LD_LOAD);
  assign xfer  = txv_q & tx_data_ready;
  assign pop   = (fifo_level != '0) && (!txv_q || xfer);

  byte_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (shreg_q[DATA_NUM*8-1 -: 8]),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .level_o   (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    drop    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (printf_rise) begin
          if (room) begin
            shreg_d = send_data;
            cnt_d   = '0;
            state_d = LD_LOAD;
          end else begin
            drop = 1'b1;
          end
        end
      end
      LD_LOAD: begin
        shreg_d = shreg_q << 8;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_NUM - 1)) state_d = LD_IDLE;
        if (printf_rise) drop = 1'b1;
      end
    endcase

    ovf_d = ovf_q;
    if (ovf_clr)   ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;

    txd_d = txd_q;
    txv_d = txv_q;
    if (pop) begin
      txd_d = fifo_rd_data;
      txv_d = 1'b1;
    end else if (xfer) begin
      txv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LD_IDLE;
      printf_q <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      txd_q    <= 8'h00;
      txv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      printf_q <= printf;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
    end
  end

  assign tx_data       = txd_q;
  assign tx_data_valid = txv_q;
  assign level         = fifo_level;
  assign overflow      = ovf_q;
  assign busy          = (state_q == LD_LOAD) || (fifo_level != '0) || txv_q;

endmodule

// File: tb/tb_uart_printf_queue.sv
// Scoreboard bench for uart_printf_queue: a 4-byte-message instance and a
// 1-byte-message instance, both DEPTH=16, sharing clock and reset.
module tb_uart_printf_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] send4;
  logic        printf4, ready4, clr4, txv4, busy4, ovf4;
  logic [7:0]  txd4;
  logic [4:0]  lvl4;

  logic [7:0]  send1;
  logic        printf1, ready1, clr1, txv1, busy1, ovf1;
  logic [7:0]  txd1;
  logic [4:0]  lvl1;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp4[$];
  logic [7:0] exp1[$];
  logic [7:0] e4, e1;

  uart_printf_queue #(.DATA_NUM(4), .DEPTH(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .send_data(send4), .printf(printf4),
    .tx_data_ready(ready4), .ovf_clr(clr4), .tx_data(txd4),
    .tx_data_valid(txv4), .level(lvl4), .busy(busy4), .overflow(ovf4)
  );

  uart_printf_queue #(.DATA_NUM(1), .DEPTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .send_data(send1), .printf(printf1),
    .tx_data_ready(ready1), .ovf_clr(clr1), .tx_data(txd1),
    .tx_data_valid(txv1), .level(lvl1), .busy(busy1), .overflow(ovf1)
  );

  // Transfers happen at the next posedge; inputs are stable from posedge+1.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && txv4 === 1'b1 && ready4 === 1'b1) begin
      n_vec++;
      if (exp4.size() == 0) begin
        n_err++;
        $display("FAIL dut4_unexpected_byte: got %02h, required no transfer", txd4);
      end else begin
        e4 = exp4.pop_front();
        if (txd4 !== e4) begin
          n_err++;
          $display("FAIL dut4_byte: got %02h, required %02h", txd4, e4);
        end
      end
    end
    if (rst_n === 1'b1 && txv1 === 1'b1 && ready1 === 1'b1) begin
      n_vec++;
      if (exp1.size() == 0) begin
        n_err++;
        $display("FAIL dut1_unexpected_byte: got %02h, required no transfer", txd1);
      end else begin
        e1 = exp1.pop_front();
        if (txd1 !== e1) begin
          n_err++;
          $display("FAIL dut1_byte: got %02h, required %02h", txd1, e1);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse4(input logic [31:0] d);
    send4   = d;
    printf4 = 1'b1;
    step(1);
    printf4 = 1'b0;
  endtask

  task automatic push4(input logic [31:0] d);
    for (int b = 3; b >= 0; b--) exp4.push_back(d[b*8 +: 8]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    send4 = '0; printf4 = 0; ready4 = 0; clr4 = 0;
    send1 = '0; printf1 = 0; ready1 = 0; clr1 = 0;
    #2;
    n_vec++;
    if ({txd4, txv4, lvl4, busy4, ovf4} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_dut4: got data=%02h v=%b lvl=%0d busy=%b ovf=%b, required all 0",
               txd4, txv4, lvl4, busy4, ovf4);
    end
    n_vec++;
    if ({txd1, txv1, lvl1, busy1, ovf1} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_dut1: got data=%02h v=%b lvl=%0d busy=%b ovf=%b, required all 0",
               txd1, txv1, lvl1, busy1, ovf1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic;
    int first = -1;
    ready4 = 1'b1;
    push4(32'h41424344);
    pulse4(32'h41424344);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txv4 === 1'b1 && first < 0) first = i;
    end
    n_vec++;
    if (first != 2) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles, required 2", first);
    end
    n_vec++;
    if (exp4.size() != 0 || busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got %0d pending busy=%b, required 0 pending busy=0",
               exp4.size(), busy4);
    end
    step(1);
  endtask

  task automatic test_stall;
    ready1 = 1'b0;
    exp1.push_back(8'h5A);
    send1 = 8'h5A; printf1 = 1'b1;
    step(1);
    printf1 = 1'b0;
    step(2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_vec++;
      if (txv1 !== 1'b1 || txd1 !== 8'h5A) begin
        n_err++;
        $display("FAIL stall_hold: cycle %0d got v=%b data=%02h, required v=1 data=5a",
                 i, txv1, txd1);
      end
    end
    @(posedge clk);
    #1 ready1 = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (txv1 !== 1'b0 || exp1.size() != 0) begin
      n_err++;
      $display("FAIL stall_consume: got v=%b pending=%0d, required v=0 pending=0",
               txv1, exp1.size());
    end
    step(1);
  endtask

  task automatic drain4(input string name);
    int t = 0;
    ready4 = 1'b1;
    while ((exp4.size() != 0 || busy4 !== 1'b0) && t < 80) begin
      step(1);
      t++;
    end
    n_vec++;
    if (exp4.size() != 0 || busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d pending busy=%b, required 0 pending busy=0",
               name, exp4.size(), busy4);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] msg [7];
    msg = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243,
            32'h50515253, 32'h60616263, 32'h70717273};
    ready4 = 1'b0;
    for (int m = 0; m < 3; m++) begin
      push4(msg[m]);
      pulse4(msg[m]);
      step(9);
    end
    n_vec++;
    if (lvl4 !== 5'd11 || txv4 !== 1'b1 || txd4 !== 8'h10 || ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_three: got lvl=%0d v=%b data=%02h ovf=%b, required 11 1 10 0",
               lvl4, txv4, txd4, ovf4);
    end
    push4(msg[3]);
    pulse4(msg[3]);
    step(9);
    n_vec++;
    if (lvl4 !== 5'd15 || ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_fourth: got lvl=%0d ovf=%b, required 15 0", lvl4, ovf4);
    end
    pulse4(msg[4]);
    step(9);
    n_vec++;
    if (lvl4 !== 5'd15 || ovf4 !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_fifth: got lvl=%0d ovf=%b, required 15 1", lvl4, ovf4);
    end
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    n_vec++;
    if (ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear1: got %b, required 0", ovf4);
    end
    ready4 = 1'b1;
    step(3);
    ready4 = 1'b0;
    step(1);
    n_vec++;
    if (lvl4 !== 5'd12) begin
      n_err++;
      $display("FAIL ovf_after3: got lvl=%0d, required 12", lvl4);
    end
    push4(msg[5]);
    pulse4(msg[5]);
    step(9);
    n_vec++;
    if (lvl4 !== 5'd16 || ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_exact_fill: got lvl=%0d ovf=%b, required 16 0", lvl4, ovf4);
    end
    pulse4(msg[6]);
    step(9);
    n_vec++;
    if (lvl4 !== 5'd16 || ovf4 !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full_drop: got lvl=%0d ovf=%b, required 16 1", lvl4, ovf4);
    end
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    n_vec++;
    if (ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear2: got %b, required 0", ovf4);
    end
    drain4("ovf");
  endtask

  task automatic test_back_to_back;
    ready4 = 1'b0;
    step(1);
    push4(32'h81828384);
    send4 = 32'h81828384; printf4 = 1'b1;
    step(1);
    printf4 = 1'b0;
    step(1);
    send4 = 32'h91929394; printf4 = 1'b1;
    step(1);
    printf4 = 1'b0;
    step(6);
    n_vec++;
    if (ovf4 !== 1'b1 || lvl4 !== 5'd3 || txv4 !== 1'b1 || txd4 !== 8'h81) begin
      n_err++;
      $display("FAIL b2b_state: got ovf=%b lvl=%0d v=%b data=%02h, required 1 3 1 81",
               ovf4, lvl4, txv4, txd4);
    end
    clr4 = 1'b1;
    step(1);
    clr4 = 1'b0;
    drain4("b2b");
  endtask

  task automatic test_wrap;
    int msg = 0;
    int t = 0;
    for (int i = 0; i < 160; i++) begin
      ready1 = ($urandom_range(0, 3) != 0);
      if (i % 4 == 0 && msg < 40) begin
        send1   = 8'(msg);
        printf1 = 1'b1;
        exp1.push_back(8'(msg));
        msg++;
      end else begin
        printf1 = 1'b0;
      end
      step(1);
    end
    printf1 = 1'b0;
    ready1  = 1'b1;
    while ((exp1.size() != 0 || busy1 !== 1'b0) && t < 100) begin
      step(1);
      t++;
    end
    n_vec++;
    if (exp1.size() != 0 || busy1 !== 1'b0 || ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_drain: got %0d pending busy=%b ovf=%b, required 0 0 0",
               exp1.size(), busy1, ovf1);
    end
  endtask

  task automatic test_reset_mid_load;
    bit seen = 1'b0;
    ready4 = 1'b0;
    step(1);
    pulse4(32'hA1A2A3A4);
    step(2);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({txd4, txv4, lvl4, busy4, ovf4} !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid_load: got data=%02h v=%b lvl=%0d busy=%b ovf=%b, required all 0",
               txd4, txv4, lvl4, busy4, ovf4);
    end
    exp4.delete();
    step(2);
    rst_n  = 1'b1;
    ready4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txv4 !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL rst_no_output: got activity after reset, required none");
    end
    step(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
